// File: rtl/regs_wb_pkg.sv
// Shared types and defaults for the register-file write-back arbiter.
// Used by regs_wb_arbiter and its round-robin arbiter sub-module.
package regs_wb_pkg;

    localparam int N_REQ_DEF = 3;
    localparam int DW_DEF    = 32;
    localparam int AW_DEF    = 5;
    localparam int REG_X0    = 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Round-robin pointer width; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans from ptr upward, wrapping,
// and returns the one-hot grant plus the winner index of the first valid requester.
module rr_arbiter
    import regs_wb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int PW    = ptr_width(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PW-1:0]    winner,
    output logic             any_valid
);

    logic [PW-1:0] idx;

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        grant     = '0;
        winner    = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = PW'((int'(ptr) + i) % N_REQ);
            if (!any_valid && valid[idx]) begin
                grant[idx] = 1'b1;
                winner     = idx;
                any_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regs_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between N_REQ requesters.
// Define REGS_WB_ARBITER_CLEAR_EN to add the x1..x31 zero-fill sweep.
module regs_wb_arbiter
    import regs_wb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic                i_CLK,
    input  logic                i_RST,
    input  logic [N_REQ-1:0]    i_req_valid,
    output logic [N_REQ-1:0]    o_req_ready,
    input  logic [N_REQ*AW-1:0] i_req_sel,
    input  logic [N_REQ*DW-1:0] i_req_data,
    output logic [AW-1:0]       o_reg_w_sel,
    output logic [DW-1:0]       o_reg_w_data,
    output logic [N_REQ-1:0]    o_grant_oh,
    input  logic                i_clr_start,
    output logic                o_clr_busy
);

    localparam int PW = ptr_width(N_REQ);

    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    ptr_d;
    logic [N_REQ-1:0] arb_grant;
    logic [PW-1:0]    arb_winner;
    logic             arb_any;
    logic             arb_en;
    logic             transfer;
    logic [AW-1:0]    sel_d;
    logic [DW-1:0]    data_d;
    logic [N_REQ-1:0] grant_d;

`ifdef REGS_WB_ARBITER_CLEAR_EN
    localparam logic [AW-1:0] SEL_LAST = '1;

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;

    assign arb_en     = (state_q == ST_IDLE);
    assign o_clr_busy = (state_q == ST_CLEAR);
`else
    logic unused_clr_start;

    assign arb_en           = 1'b1;
    assign o_clr_busy       = 1'b0;
    assign unused_clr_start = i_clr_start;
`endif

    rr_arbiter #(
        .N_REQ(N_REQ),
        .PW   (PW)
    ) u_rr_arbiter (
        .valid    (i_req_valid),
        .ptr      (ptr_q),
        .grant    (arb_grant),
        .winner   (arb_winner),
        .any_valid(arb_any)
    );

    // Ready is forced low during reset so nothing is accepted while state is undefined.
    assign transfer    = arb_any && arb_en && !i_RST;
    assign o_req_ready = transfer ? arb_grant : '0;

    always_comb begin
        ptr_d   = ptr_q;
        sel_d   = AW'(REG_X0);
        data_d  = o_reg_w_data;
        grant_d = '0;
        if (transfer) begin
            ptr_d   = (arb_winner == PW'(N_REQ - 1)) ? '0 : arb_winner + 1'b1;
            grant_d = arb_grant;
            for (int k = 0; k < N_REQ; k++) begin
                if (arb_grant[k]) begin
                    sel_d  = i_req_sel[k*AW +: AW];
                    data_d = i_req_data[k*DW +: DW];
                end
            end
        end
`ifdef REGS_WB_ARBITER_CLEAR_EN
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_clr_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = AW'(1);
                end
            end
            ST_CLEAR: begin
                sel_d  = cnt_q;
                data_d = '0;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == SEL_LAST)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
`endif
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            ptr_q        <= '0;
            o_reg_w_sel  <= '0;
            o_reg_w_data <= '0;
            o_grant_oh   <= '0;
        end else begin
            ptr_q        <= ptr_d;
            o_reg_w_sel  <= sel_d;
            o_reg_w_data <= data_d;
            o_grant_oh   <= grant_d;
        end
    end

`ifdef REGS_WB_ARBITER_CLEAR_EN
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Self-checking bench for regs_wb_arbiter: directed steps plus a randomized phase,
// all compared against a cycle-level behavioural model and a modelled register file.
module tb_regs_wb_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 5;

    logic            i_CLK = 1'b0;
    logic            i_RST;
    logic [N-1:0]    valid;
    logic [N-1:0]    o_req_ready;
    logic [AW-1:0]   sel_a  [N];
    logic [DW-1:0]   data_a [N];
    logic [N*AW-1:0] sel_pk;
    logic [N*DW-1:0] data_pk;
    logic [AW-1:0]   o_reg_w_sel;
    logic [DW-1:0]   o_reg_w_data;
    logic [N-1:0]    o_grant_oh;
    logic            clr_start;
    logic            o_clr_busy;

    logic [DW-1:0]   rf [32];

    int vectors;
    int miscompares;

    // behavioural model state
    int            m_ptr;
    logic [AW-1:0] m_sel;
    logic [DW-1:0] m_data;
    logic [N-1:0]  m_grant;
    bit            m_clr;
    int            m_cnt;
    logic [N-1:0]  last_ready;

    regs_wb_arbiter #(.N_REQ(N), .DW(DW), .AW(AW)) dut (
        .i_CLK       (i_CLK),
        .i_RST       (i_RST),
        .i_req_valid (valid),
        .o_req_ready (o_req_ready),
        .i_req_sel   (sel_pk),
        .i_req_data  (data_pk),
        .o_reg_w_sel (o_reg_w_sel),
        .o_reg_w_data(o_reg_w_data),
        .o_grant_oh  (o_grant_oh),
        .i_clr_start (clr_start),
        .o_clr_busy  (o_clr_busy)
    );

    always #5 i_CLK = ~i_CLK;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            sel_pk[k*AW +: AW]  = sel_a[k];
            data_pk[k*DW +: DW] = data_a[k];
        end
    end

    // Register file attached to the write port; x0 never written.
    always @(posedge i_CLK) begin
        if (o_reg_w_sel != 0)
            rf[o_reg_w_sel] <= o_reg_w_data;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        m_ptr   = 0;
        m_sel   = '0;
        m_data  = '0;
        m_grant = '0;
        m_clr   = 1'b0;
        m_cnt   = 0;
    endtask

    function automatic logic [N-1:0] exp_ready();
        if (m_clr)
            return '0;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (valid[k])
                return N'(1) << k;
        end
        return '0;
    endfunction

    // One clock: inputs already driven at posedge+1; returns at next posedge+1.
    task automatic cycle();
        logic [N-1:0] er;
        int           w;
        er = exp_ready();
        #1;
        check("ready", o_req_ready, er);
        @(posedge i_CLK);
        if (m_clr) begin
            m_sel   = AW'(m_cnt);
            m_data  = '0;
            m_grant = '0;
            if (m_cnt == 31) m_clr = 1'b0;
            else             m_cnt++;
        end else begin
            if (er != 0) begin
                w = 0;
                for (int i = 0; i < N; i++) if (er[i]) w = i;
                m_sel   = sel_a[w];
                m_data  = data_a[w];
                m_grant = er;
                m_ptr   = (w + 1) % N;
            end else begin
                m_sel   = '0;
                m_grant = '0;
            end
`ifdef REGS_WB_ARBITER_CLEAR_EN
            if (clr_start) begin
                m_clr = 1'b1;
                m_cnt = 1;
            end
`endif
        end
        last_ready = er;
        #1;
        check("w_sel", o_reg_w_sel, m_sel);
        check("w_data", o_reg_w_data, m_data);
        check("grant_oh", o_grant_oh, m_grant);
        check("clr_busy", o_clr_busy, m_clr);
    endtask

    initial begin
        logic [N-1:0] rot [6];
        vectors     = 0;
        miscompares = 0;
        clr_start   = 1'b0;
        last_ready  = '0;
        mdl_reset();

        // Reset with every requester valid
        i_RST     = 1'b1;
        valid     = 3'b111;
        sel_a[0]  = 5'd1;  sel_a[1]  = 5'd2;  sel_a[2]  = 5'd3;
        data_a[0] = 32'h11; data_a[1] = 32'h22; data_a[2] = 32'h33;
        repeat (2) @(posedge i_CLK);
        #1;
        check("rst_ready", o_req_ready, 3'b000);
        check("rst_sel", o_reg_w_sel, 5'd0);
        check("rst_data", o_reg_w_data, 32'h0);
        check("rst_grant", o_grant_oh, 3'b000);
        check("rst_busy", o_clr_busy, 1'b0);
        i_RST = 1'b0;
        cycle();
        check("first_grant", o_grant_oh, 3'b001);
        check("first_sel", o_reg_w_sel, 5'd1);

        // Single requester 1 writing x5
        valid = 3'b000;
        cycle();
        valid     = 3'b010;
        sel_a[1]  = 5'd5;
        data_a[1] = 32'hDEADBEEF;
        cycle();
        check("r1_sel", o_reg_w_sel, 5'd5);
        check("r1_data", o_reg_w_data, 32'hDEADBEEF);
        check("r1_grant", o_grant_oh, 3'b010);
        valid = 3'b000;
        cycle();
        cycle();
        check("readback_x5", rf[5], 32'hDEADBEEF);

        // Select 0 is accepted and advances the pointer
        valid     = 3'b100;
        sel_a[2]  = 5'd0;
        data_a[2] = 32'h1234;
        cycle();
        check("x0_grant", o_grant_oh, 3'b100);
        check("x0_sel", o_reg_w_sel, 5'd0);

        // Fairness: all valid, rotation 0,1,2,0,1,2
        valid    = 3'b111;
        sel_a[0] = 5'd7; sel_a[1] = 5'd8; sel_a[2] = 5'd9;
        rot[0] = 3'b001; rot[1] = 3'b010; rot[2] = 3'b100;
        rot[3] = 3'b001; rot[4] = 3'b010; rot[5] = 3'b100;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("rotation", o_grant_oh, rot[i]);
        end
        valid = 3'b000;
        cycle();

`ifdef REGS_WB_ARBITER_CLEAR_EN
        // Preload x1..x31 with nonzero data
        valid = 3'b010;
        for (int r = 1; r < 32; r++) begin
            sel_a[1]  = AW'(r);
            data_a[1] = $urandom | 32'h1;
            cycle();
        end
        valid = 3'b000;
        cycle();

        // Sweep started alongside a pending req0 write
        valid     = 3'b001;
        sel_a[0]  = 5'd0;
        data_a[0] = 32'hC0FFEE;
        clr_start = 1'b1;
        cycle();
        clr_start = 1'b0;
        check("sweep_start_busy", o_clr_busy, 1'b1);
        for (int s = 0; s < 31; s++) begin
            if (s == 5) clr_start = 1'b1;
            cycle();
            clr_start = 1'b0;
        end
        check("sweep_end_busy", o_clr_busy, 1'b0);
        cycle();
        check("post_sweep_grant", o_grant_oh, 3'b001);
        valid = 3'b000;
        cycle();
        cycle();
        for (int r = 1; r < 32; r++)
            check("swept_reg", rf[r], 32'h0);

        // Reset in the middle of a sweep
        valid     = 3'b010;
        sel_a[1]  = 5'd3;
        data_a[1] = 32'h5A5A;
        cycle();
        valid     = 3'b000;
        clr_start = 1'b1;
        cycle();
        clr_start = 1'b0;
        repeat (9) cycle();
        i_RST = 1'b1;
        #1;
        check("abort_busy", o_clr_busy, 1'b0);
        check("abort_sel", o_reg_w_sel, 5'd0);
        check("abort_ready", o_req_ready, 3'b000);
        valid = 3'b111;
        @(posedge i_CLK);
        #1;
        check("abort_rst_ready", o_req_ready, 3'b000);
        i_RST = 1'b0;
        mdl_reset();
        cycle();
        check("abort_ptr0", o_grant_oh, 3'b001);
        valid = 3'b000;
        cycle();
`else
        // Without the sweep feature the start pulse is ignored
        valid     = 3'b001;
        sel_a[0]  = 5'd4;
        data_a[0] = 32'hC0FFEE;
        clr_start = 1'b1;
        cycle();
        clr_start = 1'b0;
        valid     = 3'b000;
        cycle();
        check("no_clr_busy", o_clr_busy, 1'b0);
`endif

        // Randomized traffic obeying the hold-until-ready rule
        valid = 3'b000;
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < N; k++) begin
                if (last_ready[k] || !valid[k]) begin
                    valid[k] = ($urandom_range(0, 2) != 0);
                    if (valid[k]) begin
                        sel_a[k]  = AW'($urandom_range(0, 31));
                        data_a[k] = $urandom;
                    end
                end
            end
            clr_start = ($urandom_range(0, 63) == 0);
            cycle();
            clr_start = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regs_wb_arbiter.md
Name: regs_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file (x0 hard-wired zero) between N_REQ write-back requesters, e.g. ALU, load unit and debug port.
- Uses round-robin arbitration with a per-requester valid/ready handshake.
- Registers the winning write onto the register-file write select/data inputs.
- Optionally sequences a zero-fill sweep of x1..x31 on command.

Parameters:
- N_REQ, 3, number of write requesters (2..8)
- DW, 32, register data width
- AW, 5, register select width; register count = 2^AW, index 0 is x0

Ports:
- i_CLK  in  1  clock, all state on rising edge
- i_RST  in  1  reset, asynchronous, active-high
- i_req_valid  in  N_REQ  per-requester write request
- o_req_ready  out  N_REQ  per-requester grant, one-hot or zero, combinational
- i_req_sel  in  N_REQ*AW  packed destination selects, requester k at [k*AW +: AW]
- i_req_data  in  N_REQ*DW  packed write data, requester k at [k*DW +: DW]
- o_reg_w_sel  out  AW  register-file write select, registered; 0 means no write
- o_reg_w_data  out  DW  register-file write data, registered
- o_grant_oh  out  N_REQ  registered copy of the accepted grant, for tracing
- i_clr_start  in  1  zero-fill sweep request, single-cycle pulse
- o_clr_busy  out  1  sweep in progress, registered

Behaviour:
- Reset (asynchronous, on i_RST high):
  - state=IDLE, rr pointer=0, sweep counter=0.
  - o_reg_w_sel=0, o_reg_w_data=0, o_grant_oh=0, o_clr_busy=0.
- o_req_ready is combinational and 0 while i_RST is high.
- States: IDLE (arbitrate) and CLEAR (sweep). CLEAR exists only with the optional feature.
- IDLE arbitration:
  - Scan requesters from index ptr upward, wrapping modulo N_REQ.
  - The first requester with valid set wins; o_req_ready = one-hot of the winner.
  - If no requester is valid, o_req_ready = 0.
- Handshake:
  - A transfer occurs on an edge where valid & ready are both high.
  - A requester must hold valid, sel and data stable until ready.
  - o_req_ready depends on i_req_valid, so a requester must not derive valid from ready.
- Pointer update:
  - On a transfer by requester k, ptr <= (k+1) mod N_REQ.
  - With no transfer, ptr holds.
  - At most one transfer per cycle.
- Output stage:
  - On a transfer, o_reg_w_sel/o_reg_w_data/o_grant_oh <= winner's sel, winner's data, winner's one-hot.
  - With no transfer, o_reg_w_sel <= 0 and o_grant_oh <= 0; o_reg_w_data holds.
- Latency:
  - Write select/data appear 1 cycle after the handshake edge.
  - The register file captures them on the following edge.
  - Readback is therefore valid 2 edges after the handshake.
- A request with sel=0 is accepted and advances the pointer. It produces o_reg_w_sel=0, so no register-file write occurs.
- Fairness: with all N_REQ valid continuously, grants rotate 0,1,...,N_REQ-1,0,...; no requester waits more than N_REQ-1 transfers.

Optional Feature:
- Macro: REGS_WB_ARBITER_CLEAR_EN.
- Defined:
  - i_clr_start seen in IDLE → CLEAR on the next edge, counter=1, o_clr_busy=1.
  - Pending arbitration in that start cycle still completes normally.
  - In CLEAR, o_req_ready=0 for all requesters.
  - Each cycle, o_reg_w_sel<=counter and o_reg_w_data<=0, then counter increments.
  - After the cycle with counter=2^AW-1, the block returns to IDLE and o_clr_busy<=0.
  - Sweep takes 31 cycles for AW=5; the pointer is preserved across it.
  - i_clr_start during CLEAR is ignored.
  - i_RST mid-sweep aborts to IDLE immediately.
- Undefined:
  - The CLEAR state and counter are removed.
  - i_clr_start is ignored and o_clr_busy is tied 0.
  - Ports are unchanged.

Decomposition:
- Package regs_wb_pkg: default DW/AW, REG_X0 constant (0), state encoding ST_IDLE/ST_CLEAR, pointer width PW=$clog2(N_REQ).
- Sub-module rr_arbiter: valid vector + ptr in, combinational one-hot grant and winner index out; the pointer register stays in the parent.

Test Plan:
- Reset with all valid high: o_req_ready=0 and outputs 0 while i_RST=1. First edge after release grants req0; next cycle o_reg_w_sel=req0 sel.
- Only req1 valid, sel=5, data=32'hDEADBEEF: ready[1]=1 same cycle. Next cycle o_reg_w_sel=5, o_reg_w_data=DEADBEEF, o_grant_oh=3'b010. Readback x5=DEADBEEF after 2 edges.
- All three valid for 6 cycles, each holding a distinct sel: grant order 0,1,2,0,1,2 with no gaps.
- req2 valid with sel=0, data=32'h1234: accepted (ready[2]=1), next cycle o_reg_w_sel=0; pointer then favours req0.
- CLEAR_EN, pulse i_clr_start with req0 valid: req0 serviced, then o_clr_busy=1 for 31 cycles with o_reg_w_sel=1..31 and data 0, ready=0 throughout. Afterwards x1..x31 read 0 and req0 is serviced again.
- CLEAR_EN, assert i_RST at sweep step 10: o_clr_busy=0 and o_reg_w_sel=0 immediately, without waiting for an edge. After release, the block is IDLE with ptr=0.
